// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and frame-length helper for spi_master
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

    // Cycles from one accept edge to the earliest possible next accept edge.
    function automatic int spi_frame_cycles(input int width, input int clk_div);
        return clk_div * (2 * width + 2) + 1;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// rtl/spi_phase_timer.sv - loadable down-counter marking the last cycle of each SCK half-period
module spi_phase_timer #(
    parameter int clk_div = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic expire_o
);

    localparam int CW = (clk_div > 1) ? $clog2(clk_div) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= CW'(clk_div - 1);
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI frame transmitter; SPI_MASTER_MISO_EN adds MISO capture into rx_data
module spi_master
    import spi_pkg::*;
#(
    parameter int width   = 24,
    parameter int clk_div = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             done,
    output logic             nCS,
    output logic             SCK,
    output logic             MOSI
`ifdef SPI_MASTER_MISO_EN
    ,
    input  logic             MISO,
    output logic [width-1:0] rx_data
`endif
);

    localparam int BW = $clog2(width + 1);

    spi_state_t       state_q, state_d;
    logic [width-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             ready_q, done_q, ncs_q, sck_q, mosi_q;
    logic             accept, timer_load, expire;

    assign accept = valid && ready_q;

    spi_phase_timer #(.clk_div(clk_div)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .expire_o (expire)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SETUP;
                    shift_d    = data;
                    bit_cnt_d  = BW'(width);
                    timer_load = 1'b1;
                end
            end
            SETUP: begin
                if (expire) begin
                    state_d    = HIGH;
                    timer_load = 1'b1;
                end
            end
            HIGH: begin
                if (expire) begin
                    timer_load = 1'b1;
                    bit_cnt_d  = bit_cnt_q - BW'(1);
                    if (bit_cnt_q == BW'(1)) begin
                        state_d = HOLD;
                    end else begin
                        // Next bit appears on the same cycle SCK falls.
                        state_d = LOW;
                        shift_d = shift_q << 1;
                    end
                end
            end
            LOW: begin
                if (expire) begin
                    state_d    = HIGH;
                    timer_load = 1'b1;
                end
            end
            HOLD: begin
                if (expire) begin
                    state_d    = GAP;
                    timer_load = 1'b1;
                end
            end
            GAP: begin
                if (expire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so pins change together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            ncs_q     <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ready_q   <= (state_d == IDLE);
            done_q    <= (state_q == HOLD) && (state_d == GAP);
            ncs_q     <= (state_d == IDLE) || (state_d == GAP);
            sck_q     <= (state_d == HIGH);
            mosi_q    <= ((state_d == SETUP) || (state_d == HIGH) || (state_d == LOW))
                         && shift_d[width-1];
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign nCS   = ncs_q;
    assign SCK   = sck_q;
    assign MOSI  = mosi_q;

`ifdef SPI_MASTER_MISO_EN
    logic             sck_prev_q;
    logic [width-1:0] rx_shift_q, rx_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_prev_q <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            sck_prev_q <= sck_q;
            if (sck_q && !sck_prev_q) begin
                rx_shift_q <= width'({rx_shift_q, MISO});
            end
            if ((state_q == HOLD) && (state_d == GAP)) begin
                rx_data_q <= rx_shift_q;
            end
        end
    end

    assign rx_data = rx_data_q;
`endif

endmodule
